mdu_seq: RTL and testbench

- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair. It is the sequential successor to the combinational ALU multiply path.
- Performs signed and unsigned multiply, multiply-accumulate and divide using a radix-2 shift-add / restoring-subtract datapath, one bit per cycle.
- Sits beside the ALU in the execute stage. The core stalls on busy_o and takes results from hi_o/lo_o.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_iter_step.sv | 40 ++++
 rtl/mdu_seq.sv | 191 +++++++++++++++++++
 tb/tb_mdu_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: opcodes, FSM states, default width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MUL   = 3'b000,
    MULU  = 3'b001,
    MADD  = 3'b010,
    MADDU = 3'b011,
    DIV   = 3'b100,
    DIVU  = 3'b101,
    MTHI  = 3'b110,
    MTLO  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring-divide step when MDU_DIV_EN is defined.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    shifted = {hi_i, lo_i[WIDTH-1]};
    diff    = shifted - {1'b0, b_i};
    if (is_div_i) begin
      // diff[WIDTH] set means the trial subtract borrowed; keep the shifted remainder.
      hi_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit owning HI/LO. Divide support is compiled in by MDU_DIV_EN.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d, op_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] wk_hi_q, wk_hi_d, wk_lo_q, wk_lo_d, opb_q, opb_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             done_q, done_d, err_q, err_d;
  logic             pend_q, pend_d, pend_err_q, pend_err_d;

  logic             sa, sb, launch, op_div_q;
  logic [WIDTH-1:0] mag_a, mag_b, step_hi, step_lo;

  assign op_in    = mdu_op_e'(op_i);
  assign op_div_q = (op_q == DIV) || (op_q == DIVU);

  // Signed ops have op bit 0 clear; unsigned ops force the sign flags low.
  assign sa    = ~op_i[0] & a_i[WIDTH-1];
  assign sb    = ~op_i[0] & b_i[WIDTH-1];
  assign mag_a = sa ? (~a_i + ONE_W) : a_i;
  assign mag_b = sb ? (~b_i + ONE_W) : b_i;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_div_q),
    .hi_i     (wk_hi_q),
    .lo_i     (wk_lo_q),
    .b_i      (opb_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wk_hi_d    = wk_hi_q;
    wk_lo_d    = wk_lo_q;
    opb_d      = opb_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    done_d     = pend_q;
    err_d      = pend_q & pend_err_q;
    pend_d     = 1'b0;
    pend_err_d = 1'b0;
    launch     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d = op_in;
          case (op_in)
            MTHI: begin
              hi_d   = a_i;
              pend_d = 1'b1;
            end
            MTLO: begin
              lo_d   = a_i;
              pend_d = 1'b1;
            end
            DIV, DIVU: begin
`ifdef MDU_DIV_EN
              if (b_i == '0) begin
                pend_d     = 1'b1;
                pend_err_d = 1'b1;
              end else begin
                launch = 1'b1;
              end
`else
              pend_d     = 1'b1;
              pend_err_d = 1'b1;
`endif
            end
            default: launch = 1'b1;
          endcase
          if (launch) begin
            state_d   = RUN;
            cnt_d     = '0;
            wk_hi_d   = '0;
            wk_lo_d   = mag_a;
            opb_d     = mag_b;
            neg_res_d = sa ^ sb;
            neg_rem_d = sa;
          end
        end
      end
      RUN: begin
        wk_hi_d = step_hi;
        wk_lo_d = step_lo;
        cnt_d   = cnt_q + ONE_C;
        if (cnt_q == LAST) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        // Two FIX cycles: sign correction first, then accumulate and write HI/LO.
        if (cnt_q == '0) begin
          cnt_d = ONE_C;
`ifdef MDU_DIV_EN
          if (op_div_q) begin
            wk_lo_d = neg_res_q ? (~wk_lo_q + ONE_W) : wk_lo_q;
            wk_hi_d = neg_rem_q ? (~wk_hi_q + ONE_W) : wk_hi_q;
          end else
`endif
          begin
            {wk_hi_d, wk_lo_d} = neg_res_q ? (~{wk_hi_q, wk_lo_q} + ONE_2W)
                                           : {wk_hi_q, wk_lo_q};
          end
        end else begin
          if ((op_q == MADD) || (op_q == MADDU)) begin
            {hi_d, lo_d} = {hi_q, lo_q} + {wk_hi_q, wk_lo_q};
          end else begin
            {hi_d, lo_d} = {wk_hi_q, wk_lo_q};
          end
          done_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= MUL;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      wk_hi_q    <= '0;
      wk_lo_q    <= '0;
      opb_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wk_hi_q    <= wk_hi_d;
      wk_lo_q    <= wk_lo_d;
      opb_q      <= opb_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq (WIDTH=32); DIV expectations follow MDU_DIV_EN.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULU = 3'd1, OP_MADD = 3'd2, OP_MADDU = 3'd3,
                         OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7;

  mdu_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Edges from accept to done (-1 on timeout) and how many cycles showed busy before it.
  task automatic wait_done(output int n, output int nbusy);
    n = -1; nbusy = 0;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(posedge clk); #1;
      if (done_o) n = i;
      else if (busy_o) nbusy++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got %b want 000", {busy_o, done_o, err_o});
    end
    n_cmp++;
    if ({hi_o, lo_o} !== 64'h0) begin
      n_bad++; $display("FAIL reset_hilo got %h want 0", {hi_o, lo_o});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n, nb;
    issue(OP_MUL, 32'hFFFFFFFE, 32'd3);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 34) begin n_bad++; $display("FAIL mul_latency got %0d want 34", n); end
    n_cmp++;
    if (nb !== 33) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 33", nb); end
    n_cmp++;
    if ({busy_o, err_o} !== 2'b00) begin
      n_bad++; $display("FAIL mul_busy_err got %b want 00", {busy_o, err_o});
    end
    n_cmp++;
    if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_bad++; $display("FAIL mul_result got %h want FFFFFFFFFFFFFFFA", {hi_o, lo_o});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0) begin n_bad++; $display("FAIL mul_done_pulse got %b want 0", done_o); end
  endtask

  task automatic test_madd_carry();
    int n, nb;
    issue(OP_MTHI, 32'h0, 32'h0);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 1 || nb !== 0 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL mthi_timing got n=%0d busy=%0d err=%b want 1/0/0", n, nb, err_o);
    end
    issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    wait_done(n, nb);
    n_cmp++;
    if ({hi_o, lo_o} !== 64'h00000000_FFFFFFFF) begin
      n_bad++; $display("FAIL mtlo_value got %h want 00000000FFFFFFFF", {hi_o, lo_o});
    end
    issue(OP_MADDU, 32'd1, 32'd1);
    @(posedge clk); #1;
    issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 32) begin n_bad++; $display("FAIL maddu_latency got %0d want 32", n); end
    n_cmp++;
    if ({hi_o, lo_o} !== 64'h00000001_00000000) begin
      n_bad++; $display("FAIL maddu_carry got %h want 0000000100000000", {hi_o, lo_o});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || hi_o !== 32'h1) begin
      n_bad++; $display("FAIL busy_start_ignored got done=%b hi=%h want 0/00000001", done_o, hi_o);
    end
  endtask

  task automatic test_div();
    int n, nb;
    logic [31:0] ehi, elo;
    logic        eerr;
    int          en;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n, nb);
`ifdef MDU_DIV_EN
    en = 34; eerr = 1'b0; ehi = 32'hFFFFFFFF; elo = 32'hFFFFFFFD;
`else
    en = 1; eerr = 1'b1; ehi = 32'h1; elo = 32'h0;
`endif
    n_cmp++;
    if (n !== en || err_o !== eerr) begin
      n_bad++; $display("FAIL div_timing got n=%0d err=%b want %0d/%b", n, err_o, en, eerr);
    end
    n_cmp++;
    if (hi_o !== ehi || lo_o !== elo) begin
      n_bad++; $display("FAIL div_signed got hi=%h lo=%h want %h/%h", hi_o, lo_o, ehi, elo);
    end
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    wait_done(n, nb);
`ifdef MDU_DIV_EN
    ehi = 32'h1; elo = 32'h7FFFFFFC;
`endif
    n_cmp++;
    if (hi_o !== ehi || lo_o !== elo || err_o !== eerr) begin
      n_bad++; $display("FAIL divu got hi=%h lo=%h err=%b want %h/%h/%b", hi_o, lo_o, err_o, ehi, elo, eerr);
    end
  endtask

  task automatic test_div_zero();
    int n, nb;
    issue(OP_MTHI, 32'h1234, 32'h0);
    wait_done(n, nb);
    issue(OP_MTLO, 32'h5678, 32'h0);
    wait_done(n, nb);
    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 1 || nb !== 0 || err_o !== 1'b1) begin
      n_bad++; $display("FAIL div0_resp got n=%0d busy=%0d err=%b want 1/0/1", n, nb, err_o);
    end
    n_cmp++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
      n_bad++; $display("FAIL div0_hilo got hi=%h lo=%h want 00001234/00005678", hi_o, lo_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done_o, err_o} !== 2'b00) begin
      n_bad++; $display("FAIL div0_pulse got %b want 00", {done_o, err_o});
    end
  endtask

  task automatic test_div_ovf();
    int n, nb;
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, nb);
`ifdef MDU_DIV_EN
    n_cmp++;
    if (hi_o !== 32'h0 || lo_o !== 32'h80000000 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL div_ovf got hi=%h lo=%h err=%b want 0/80000000/0", hi_o, lo_o, err_o);
    end
`else
    n_cmp++;
    if (hi_o !== 32'h1234 || lo_o !== 32'h5678 || err_o !== 1'b1) begin
      n_bad++; $display("FAIL div_ovf got hi=%h lo=%h err=%b want 1234/5678/1", hi_o, lo_o, err_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int n, nb;
    issue(OP_MULU, 32'd3, 32'd5);
    wait_done(n, nb);
    n_cmp++;
    if ({hi_o, lo_o} !== 64'd15) begin
      n_bad++; $display("FAIL b2b_first got %h want 000000000000000F", {hi_o, lo_o});
    end
    issue(OP_MUL, 32'd7, 32'hFFFFFFFF);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 34 || {hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF9) begin
      n_bad++; $display("FAIL b2b_second got n=%0d val=%h want 34/FFFFFFFFFFFFFFF9", n, {hi_o, lo_o});
    end
    issue(OP_MADD, 32'hFFFFFFFF, 32'd2);
    wait_done(n, nb);
    n_cmp++;
    if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF7) begin
      n_bad++; $display("FAIL madd_signed got %h want FFFFFFFFFFFFFFF7", {hi_o, lo_o});
    end
  endtask

  task automatic test_reset_mid();
    int n, nb, seen;
    issue(OP_MULU, 32'hFFFFFFFF, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy_o, done_o} !== 2'b00 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h want all 0", busy_o, done_o, hi_o, lo_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o || busy_o) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen); end
    issue(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, nb);
    n_cmp++;
    if (n !== 34 || {hi_o, lo_o} !== 64'hFFFFFFFE_00000001) begin
      n_bad++; $display("FAIL mulu_max got n=%0d val=%h want 34/FFFFFFFE00000001", n, {hi_o, lo_o});
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_madd_carry();
    test_div();
    test_div_zero();
    test_div_ovf();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
